sum_normalizer58: RTL and testbench

- Iterative normaliser directly downstream of the 57+57 custom adder.
- Accepts the adder's 58-bit unsigned Sum and left-shifts it until bit 57 is 1.
- Returns the normalised mantissa, the total shift count and a zero flag to the exponent-adjust / rounding stage.
- Multi-cycle with valid/ready handshakes on both sides, so the adder result can be registered without a wide single-cycle leading-zero counter.

---
 rtl/sum_norm_pkg.sv | 14 +
 rtl/norm_step58.sv | 33 +++
 rtl/sum_normalizer58.sv | 115 +++++++++++
 tb/tb_sum_normalizer58.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sum_norm_pkg.sv
// Shared types and constants for the 58-bit sum normaliser.
package sum_norm_pkg;

    localparam int NORM_WIDTH = 58;
    localparam int NORM_STEP  = 8;
    localparam int NORM_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/norm_step58.sv
// One normalisation iteration: decides between done, a coarse STEP shift
// or a single-bit shift for the current working value.
module norm_step58
    import sum_norm_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH,
    parameter int STEP  = NORM_STEP,
    parameter int CNT_W = NORM_CNT_W
) (
    input  logic [WIDTH-1:0] work_i,
    output logic [WIDTH-1:0] next_o,
    output logic [CNT_W-1:0] inc_o,
    output logic             done_o
);

    // Coarse shift is safe whenever the top STEP bits are clear: the leading
    // one then sits at or below bit WIDTH-1-STEP, so it cannot be pushed out.
    always_comb begin
        next_o = work_i;
        inc_o  = '0;
        done_o = 1'b0;
        if (work_i[WIDTH-1]) begin
            done_o = 1'b1;
        end else if (work_i[WIDTH-1 -: STEP] == '0) begin
            next_o = work_i << STEP;
            inc_o  = CNT_W'(STEP);
        end else begin
            next_o = work_i << 1;
            inc_o  = CNT_W'(1);
        end
    end

endmodule

// File: rtl/sum_normalizer58.sv
// Iterative normaliser for the adder sum: shifts left until the MSB is set,
// reporting the mantissa, total shift and a zero flag via valid/ready.
module sum_normalizer58
    import sum_norm_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH,
    parameter int STEP  = NORM_STEP,
    parameter int CNT_W = NORM_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [CNT_W-1:0] out_shift,
    output logic             out_zero
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mant_q, mant_d;
    logic [CNT_W-1:0] shift_q, shift_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] step_next;
    logic [CNT_W-1:0] step_inc;
    logic             step_done;

    norm_step58 #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .CNT_W (CNT_W)
    ) u_step (
        .work_i (work_q),
        .next_o (step_next),
        .inc_o  (step_inc),
        .done_o (step_done)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_mant  = mant_q;
    assign out_shift = shift_q;
    assign out_zero  = zero_q;

    // Next-state and datapath control; result registers only change on
    // acceptance or on completion, so they hold steady in DONE and IDLE.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        mant_d  = mant_q;
        shift_d = shift_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = in_sum;
                    cnt_d  = '0;
                    if (in_sum == '0) begin
                        mant_d  = '0;
                        shift_d = '0;
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (step_done) begin
                    mant_d  = work_q;
                    shift_d = cnt_q;
                    state_d = DONE;
                end else begin
                    work_d = step_next;
                    cnt_d  = cnt_q + step_inc;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            mant_q  <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            mant_q  <= mant_d;
            shift_q <= shift_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_sum_normalizer58.sv
// Directed bench for sum_normalizer58 with an expected-result queue.
module tb_sum_normalizer58;

    localparam int W      = 58;
    localparam int CW     = 6;
    localparam int MAXLAT = 20;

    typedef struct {
        logic [W-1:0]  mant;
        logic [CW-1:0] shift;
        logic          zero;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_sum = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_mant;
    logic [CW-1:0] out_shift;
    logic          out_zero;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    sum_normalizer58 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_shift (out_shift),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Reference: leading-zero count by linear scan; latency from the
    // coarse/fine shift decomposition of that count.
    function automatic exp_t model(input logic [W-1:0] s);
        exp_t e;
        int   lz;
        lz = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (s[i]) break;
            lz++;
        end
        if (s == '0) begin
            e.mant = '0; e.shift = '0; e.zero = 1'b1; e.lat = 1;
        end else begin
            e.mant  = s << lz;
            e.shift = CW'(lz);
            e.zero  = 1'b0;
            e.lat   = 2 + lz / 8 + lz % 8;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge; drives one Sum and returns #1 after the accept edge.
    task automatic accept(input logic [W-1:0] sum);
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_sum   = sum;
        sb.push_back(model(sum));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sum   = W'({$urandom, $urandom});
        $display("accept sum=%0h", sum);
    endtask

    // Called #1 after the accept edge; waits (bounded) for out_valid and compares.
    task automatic await_result();
        int   lat;
        exp_t e;
        lat = 1;
        while (!out_valid && lat < MAXLAT) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_timeout", 64'(out_valid), 64'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk("out_mant", 64'(out_mant), 64'(e.mant));
            chk("out_shift", 64'(out_shift), 64'(e.shift));
            chk("out_zero", 64'(out_zero), 64'(e.zero));
            chk("latency", 64'(lat), 64'(e.lat));
            chk("in_ready_in_done", 64'(in_ready), 64'd0);
            $display("result mant=%0h shift=%0d zero=%0d lat=%0d", out_mant, out_shift, out_zero, lat);
        end
    endtask

    // Completes the output handshake and confirms the block is idle afterwards.
    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid_after_hs", 64'(out_valid), 64'd0);
        chk("in_ready_after_hs", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] sum);
        accept(sum);
        await_result();
        handshake();
    endtask

    initial begin
        logic [W-1:0] r;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_mant", 64'(out_mant), 64'd0);
        chk("rst_out_shift", 64'(out_shift), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(58'h200_0000_0000_0000);
        run_op(58'h1 << 49);
        run_op(58'h1);
        run_op(58'h0);
        run_op(58'h0FF_0000_0000_0001);
        run_op(58'h100_0000_0000_0000);
        for (int k = 0; k < 6; k++) begin
            r = W'({$urandom, $urandom}) >> $urandom_range(0, 57);
            run_op(r);
        end

        // Backpressure with a second request waiting upstream.
        accept(58'h3);
        out_ready = 1'b0;
        await_result();
        in_valid = 1'b1;
        in_sum   = 58'h200_0000_0000_0000;
        sb.push_back(model(58'h200_0000_0000_0000));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_mant", 64'(out_mant), 64'h300_0000_0000_0000);
            chk("bp_out_shift", 64'(out_shift), 64'd56);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        handshake();
        @(posedge clk); #1;
        in_valid = 1'b0;
        await_result();
        handshake();

        // Reset during the third NORM cycle of the worst-case input.
        accept(58'h1);
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_reset_busy", 64'(in_ready), 64'd0);
        #3 rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_mant", 64'(out_mant), 64'd0);
        chk("arst_out_shift", 64'(out_shift), 64'd0);
        chk("arst_out_zero", 64'(out_zero), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(58'h200_0000_0000_0000);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
